// File: rtl/muldiv_pkg.sv
// Shared types and constants for the execute-stage multiply/divide unit.
// Op encoding matches the decode stage's 4-bit muldiv op field.
package muldiv_pkg;

    typedef enum logic [3:0] {
        NOP   = 4'd0,
        MULT  = 4'd1,
        MULTU = 4'd2,
        DIV   = 4'd3,
        DIVU  = 4'd4,
        MFHI  = 4'd5,
        MFLO  = 4'd6,
        MTHI  = 4'd7,
        MTLO  = 4'd8
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } md_state_t;

    // Divide by zero fills the quotient with this bit.
    localparam logic DIVZ_QUOT_BIT = 1'b1;
    // Signed overflow (MIN / -1): quotient is MIN, remainder is all zeros.
    localparam logic OVF_QUOT_MSB  = 1'b1;
    localparam logic OVF_REM_BIT   = 1'b0;

endpackage

// File: rtl/muldiv_datapath.sv
// Shift-add multiply / restoring divide datapath with sign fixup; one step per cycle.
// Latency: WIDTH steps after start; results are combinational from the product register.
// Backpressure: none, sequencing comes entirely from the owning FSM.
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
`ifdef MULDIV_EARLY_OUT_EN
    , parameter int CNT_BITS = 6
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step,
    input  md_op_t           op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
`ifdef MULDIV_EARLY_OUT_EN
    input  logic [CNT_BITS-1:0] cnt,
    output logic             early_done,
`endif
    output logic [WIDTH-1:0] hi_res,
    output logic [WIDTH-1:0] lo_res
);

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   opnd;
    logic               is_div, neg_lo, neg_hi, divz, ovf;

    logic               sgn, sa, sb;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum, div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] step_next, prod_neg;

    always_comb begin
        sgn   = (op == MULT) || (op == DIV);
        sa    = sgn & src_a[WIDTH-1];
        sb    = sgn & src_b[WIDTH-1];
        mag_a = sa ? (~src_a + WIDTH'(1)) : src_a;
        mag_b = sb ? (~src_b + WIDTH'(1)) : src_b;
    end

    // Multiply: low half holds unconsumed multiplier bits, product grows in from the top.
    // Divide: {remainder, dividend/quotient} shifts left one bit per step.
    always_comb begin
        mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opnd} : '0);
        div_shift = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opnd};
        div_rem   = div_ge ? WIDTH'(div_shift - {1'b0, opnd}) : div_shift[WIDTH-1:0];
        if (is_div)
            step_next = {div_rem, prod[WIDTH-2:0], div_ge};
        else
            step_next = {mul_sum, prod[WIDTH-1:1]};
`ifdef MULDIV_EARLY_OUT_EN
        // Remaining multiplier bits sit in prod[cnt-1:0]; if all zero only shifts remain.
        early_done = !is_div && ((prod[WIDTH-1:0] << (WIDTH - int'(cnt))) == '0);
        if (early_done)
            step_next = prod >> cnt;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod   <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            divz   <= 1'b0;
            ovf    <= 1'b0;
        end else if (start) begin
            prod   <= {{WIDTH{1'b0}}, mag_a};
            opnd   <= mag_b;
            is_div <= (op == DIV) || (op == DIVU);
            neg_lo <= sa ^ sb;
            neg_hi <= sa;
            divz   <= ((op == DIV) || (op == DIVU)) && (src_b == '0);
            ovf    <= (op == DIV) && (src_a == MIN_VAL) && (src_b == '1);
        end else if (step) begin
            prod <= step_next;
        end
    end

    always_comb begin
        prod_neg = ~prod + (2*WIDTH)'(1);
        if (!is_div) begin
            {hi_res, lo_res} = neg_lo ? prod_neg : prod;
        end else begin
            lo_res = neg_lo ? (~prod[WIDTH-1:0] + WIDTH'(1)) : prod[WIDTH-1:0];
            hi_res = neg_hi ? (~prod[2*WIDTH-1:WIDTH] + WIDTH'(1)) : prod[2*WIDTH-1:WIDTH];
            if (divz)
                lo_res = {WIDTH{DIVZ_QUOT_BIT}};
            if (ovf) begin
                lo_res = {OVF_QUOT_MSB, {(WIDTH-1){1'b0}}};
                hi_res = {WIDTH{OVF_REM_BIT}};
            end
        end
    end

endmodule

// File: rtl/exec_muldiv_unit.sv
// Execute-stage iterative MULT/DIV unit owning HI/LO; optional MULDIV_EARLY_OUT_EN multiply early-out.
// Latency: HI/LO valid WIDTH+2 cycles after issue; MTxx writes next edge, MFxx combinational.
// Backpressure: md_stall_e holds the pipeline while busy and a muldiv op is presented.
module exec_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int CNT_BITS = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  md_op_t           md_op_e,
    input  logic             flush_e,
    input  logic [WIDTH-1:0] src_a_e,
    input  logic [WIDTH-1:0] src_b_e,
    output logic             md_stall_e,
    output logic             md_busy,
    output logic [WIDTH-1:0] md_result_e,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    md_state_t           state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q;
    logic [WIDTH-1:0]    hi_q, lo_q, hi_res, lo_res;
    logic                presented, is_iter, start, run_done;

    assign presented  = (md_op_e != NOP) && !flush_e;
    assign is_iter    = md_op_e inside {MULT, MULTU, DIV, DIVU};
    assign start      = (state_q == IDLE) && presented && is_iter;
    assign md_busy    = (state_q != IDLE);
    assign md_stall_e = md_busy && presented;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;

`ifdef MULDIV_EARLY_OUT_EN
    logic early_done;
    assign run_done = (cnt_q == CNT_BITS'(1)) || early_done;
`else
    assign run_done = (cnt_q == CNT_BITS'(1));
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (run_done) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            if (start)
                cnt_q <= CNT_BITS'(WIDTH);
            else if (state_q == RUN)
                cnt_q <= cnt_q - CNT_BITS'(1);
            if (state_q == FIX) begin
                hi_q <= hi_res;
                lo_q <= lo_res;
            end else if ((state_q == IDLE) && presented) begin
                if (md_op_e == MTHI) hi_q <= src_a_e;
                if (md_op_e == MTLO) lo_q <= src_a_e;
            end
        end
    end

    always_comb begin
        md_result_e = '0;
        if (md_op_e == MFHI)
            md_result_e = hi_q;
        else if (md_op_e == MFLO)
            md_result_e = lo_q;
    end

    muldiv_datapath #(
        .WIDTH    (WIDTH)
`ifdef MULDIV_EARLY_OUT_EN
        , .CNT_BITS (CNT_BITS)
`endif
    ) u_datapath (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .step       (state_q == RUN),
        .op         (md_op_e),
        .src_a      (src_a_e),
        .src_b      (src_b_e),
`ifdef MULDIV_EARLY_OUT_EN
        .cnt        (cnt_q),
        .early_done (early_done),
`endif
        .hi_res     (hi_res),
        .lo_res     (lo_res)
    );

endmodule

// File: doc/exec_muldiv_unit.md
Name: exec_muldiv_unit

Overview:
- Execute-stage iterative multiply/divide unit with HI/LO registers.
- Consumes operands and control latched by the decode/execute pipeline register: forwarded `src_a_e`/`src_b_e` and the muldiv op.
- Drives `md_stall_e` back to the hazard logic, which holds fetch/decode/execute while an operation is in flight.
- Returns HI/LO for MFHI/MFLO through `md_result_e`, which is muxed into the ALU result path.

Parameters:
- WIDTH, 32, operand/HI/LO width in bits.
- CNT_BITS, 6, iteration counter width; must satisfy 2^CNT_BITS > WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- md_op_e  input  4  op select, values from package md_op_t: NOP, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
- flush_e  input  1  execute-stage flush; suppresses the op presented this cycle.
- src_a_e  input  WIDTH  rs operand (multiplicand/dividend, or MTHI/MTLO data).
- src_b_e  input  WIDTH  rt operand (multiplier/divisor).
- md_stall_e  output  1  stall request to the hazard unit.
- md_busy  output  1  iterative operation in progress.
- md_result_e  output  WIDTH  HI for MFHI, LO for MFLO, 0 otherwise.
- hi_o  output  WIDTH  architectural HI register.
- lo_o  output  WIDTH  architectural LO register.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, hi_o=0, lo_o=0, md_busy=0, counter=0, internal accumulators=0.
- Reset mid-operation aborts the operation. HI/LO return to 0.
- An op is "presented" when md_op_e≠NOP and flush_e=0. With flush_e=1 the op is ignored and nothing is written.
- State machine IDLE → RUN → FIX → IDLE:
  - IDLE + MULT/MULTU/DIV/DIVU presented: capture operands.
    - For signed ops, capture magnitudes and record result signs.
    - Load counter=WIDTH and go to RUN. md_busy=1 from the next cycle.
  - RUN, multiply: one shift-add step per cycle, using a 2*WIDTH product register.
  - RUN, divide: one restoring-divide step per cycle.
  - RUN: decrement the counter; at counter==1, go to FIX.
  - FIX: apply sign correction, then write HI/LO on that edge and return to IDLE.
- Latency: the op is presented in cycle 0. HI/LO are valid from cycle WIDTH+2 (34 cycles at default).
- md_busy is high for WIDTH+1 cycles (RUN plus FIX).
- Multiply result: {HI,LO} = full 2*WIDTH product. MULT is two's-complement signed; MULTU is unsigned.
- Divide result: LO = quotient, truncated toward zero; HI = remainder, sign of the dividend.
- Divide by zero: LO = all ones, HI = dividend. Takes full latency, no exception.
- Signed overflow (−2^(WIDTH−1) / −1): LO = 0x80000000, HI = 0.
- MTHI/MTLO presented in IDLE: write HI/LO on the same edge; no stall.
- MFHI/MFLO in IDLE: md_result_e is combinational from the current HI/LO. An MTHI/MTLO presented in the same cycle is a different instruction, so no bypass is needed.
- md_stall_e = md_busy AND (presented op is any muldiv op, MFxx or MTxx).
- A stalled op is re-presented by the held pipeline. The unit accepts it in the cycle md_busy falls (after FIX).
- Non-muldiv instructions (md_op_e=NOP) never stall and continue while the unit is busy.
- flush_e during RUN/FIX has no effect on the operation in flight, which belongs to an older instruction.

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN.
- Defined: in RUN for multiply, when the remaining multiplier bits are all zero, shift the product register by the remaining count in one step and go to FIX.
  - Latency becomes variable: minimum 2 cycles of busy.
  - Divide is unchanged.
- Undefined: fixed WIDTH+1 busy cycles for every op.
- Results must be bit-identical either way.

Decomposition:
- Package muldiv_pkg: md_op_t enum (4-bit encoding), md_state_t enum {IDLE, RUN, FIX}, localparams for the divide-by-zero quotient value and overflow constants.
- One sub-module, muldiv_datapath: product/remainder shift registers, the add/subtract step, and sign fixup.
- The top level keeps the FSM, counter, HI/LO registers, stall and result muxes.

Test Plan:
- Reset mid-op: MULT issued, rst_n pulsed low at cycle 10 → hi_o=lo_o=0, md_busy=0 immediately; a new MULTU 3*4 completes with lo_o=12.
- MULT 0xFFFFFFFF*0x00000002 → hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFE at cycle 34; md_busy high for exactly 33 cycles.
- MULTU 0xFFFFFFFF*0x00000002 → hi_o=0x00000001, lo_o=0xFFFFFFFE.
- DIV −7/2 → lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF.
- DIVU 5/0 → lo_o=0xFFFFFFFF, hi_o=5.
- DIV 0x80000000/0xFFFFFFFF → lo_o=0x80000000, hi_o=0.
- MFLO presented 3 cycles after MULT → md_stall_e=1 until md_busy falls, then md_result_e=LO.
- Same scenario with flush_e=1 on the MFLO → md_stall_e=0 and nothing is written.
- MTHI 0x1234 in IDLE → hi_o=0x1234 next edge, md_stall_e=0.
- MULT presented with flush_e=1 → no state change, md_busy stays 0.
